counter_bank: RTL

Parametrised bank of NUM_CH independent up/down counters with per-channel range, programmable step, wrap-or-saturate mode, parallel load and optional ripple chaining of channel i-1 into channel i. It is the general counting primitive for address generators and nested loop indices in the accelerator controllers. It is the multi-channel successor of the single-step single counter and exposes registered wrap/saturate event pulses.

---
 rtl/counter_bank.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/counter_bank.sv
// Bank of independent up/down counters with per-channel bounds, wrap or
// saturate behaviour, parallel load and same-cycle ripple chaining.
module counter_bank #(
  parameter int NUM_CH      = 4,
  parameter int COUNT_WIDTH = 8,
  parameter int STEP_WIDTH  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_CH*COUNT_WIDTH-1:0] default_i,
  input  logic [NUM_CH*COUNT_WIDTH-1:0] min_count_i,
  input  logic [NUM_CH*COUNT_WIDTH-1:0] max_count_i,
  input  logic [NUM_CH-1:0]             sat_mode_i,
  input  logic [NUM_CH-1:0]             chain_i,
  input  logic [STEP_WIDTH-1:0]         step_i,
  input  logic [NUM_CH-1:0]             clear_i,
  input  logic [NUM_CH-1:0]             load_i,
  input  logic [NUM_CH*COUNT_WIDTH-1:0] load_val_i,
  input  logic [NUM_CH-1:0]             inc_i,
  input  logic [NUM_CH-1:0]             dec_i,
  output logic [NUM_CH*COUNT_WIDTH-1:0] count_o,
  output logic [NUM_CH-1:0]             at_max_o,
  output logic [NUM_CH-1:0]             at_min_o,
  output logic [NUM_CH-1:0]             wrap_up_o,
  output logic [NUM_CH-1:0]             wrap_dn_o,
  output logic [NUM_CH-1:0]             sat_hit_o
);

  // Two guard bits keep overflow and negative intermediates exact.
  localparam int AW = ((COUNT_WIDTH > STEP_WIDTH) ? COUNT_WIDTH : STEP_WIDTH) + 2;
  localparam int TW = NUM_CH * COUNT_WIDTH;
  localparam logic signed [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [TW-1:0]     count_q, count_d;
  logic [NUM_CH-1:0] wrap_up_q, wrap_up_d;
  logic [NUM_CH-1:0] wrap_dn_q, wrap_dn_d;
  logic [NUM_CH-1:0] sat_hit_q, sat_hit_d;

  function automatic logic signed [AW-1:0] widen(input logic [COUNT_WIDTH-1:0] v);
    widen = $signed({{(AW-COUNT_WIDTH){1'b0}}, v});
  endfunction

  // Next-state for every channel; carry_v ripples low-to-high in one cycle.
  always_comb begin
    logic signed [AW-1:0] cnt_v, mn_v, mx_v, stp_v, res_v, wr_v;
    logic                 up_v, dn_v, carry_v;
    count_d   = count_q;
    wrap_up_d = {NUM_CH{1'b0}};
    wrap_dn_d = {NUM_CH{1'b0}};
    sat_hit_d = {NUM_CH{1'b0}};
    carry_v   = 1'b0;
    cnt_v     = {AW{1'b0}};
    mn_v      = {AW{1'b0}};
    mx_v      = {AW{1'b0}};
    stp_v     = {AW{1'b0}};
    res_v     = {AW{1'b0}};
    wr_v      = {AW{1'b0}};
    up_v      = 1'b0;
    dn_v      = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_v = widen(count_q[i*COUNT_WIDTH +: COUNT_WIDTH]);
      mn_v  = widen(min_count_i[i*COUNT_WIDTH +: COUNT_WIDTH]);
      mx_v  = widen(max_count_i[i*COUNT_WIDTH +: COUNT_WIDTH]);
      if ((i > 0) && chain_i[i]) begin
        up_v  = carry_v;
        dn_v  = 1'b0;
        stp_v = ONE;
      end else begin
        up_v  = inc_i[i] & ~dec_i[i] & (step_i != {STEP_WIDTH{1'b0}});
        dn_v  = dec_i[i] & ~inc_i[i] & (step_i != {STEP_WIDTH{1'b0}});
        stp_v = $signed({{(AW-STEP_WIDTH){1'b0}}, step_i});
      end
      carry_v = 1'b0;
      res_v   = cnt_v;
      wr_v    = cnt_v;
      if (clear_i[i]) begin
        count_d[i*COUNT_WIDTH +: COUNT_WIDTH] = default_i[i*COUNT_WIDTH +: COUNT_WIDTH];
      end else if (load_i[i]) begin
        count_d[i*COUNT_WIDTH +: COUNT_WIDTH] = load_val_i[i*COUNT_WIDTH +: COUNT_WIDTH];
      end else if (up_v) begin
        res_v = cnt_v + stp_v;
        if (res_v <= mx_v) begin
          count_d[i*COUNT_WIDTH +: COUNT_WIDTH] = res_v[COUNT_WIDTH-1:0];
        end else if (sat_mode_i[i]) begin
          count_d[i*COUNT_WIDTH +: COUNT_WIDTH] = mx_v[COUNT_WIDTH-1:0];
          sat_hit_d[i] = 1'b1;
        end else begin
          // A step larger than the span lands on MIN rather than past MAX.
          wr_v = mn_v + (res_v - mx_v - ONE);
          if (wr_v > mx_v) begin
            count_d[i*COUNT_WIDTH +: COUNT_WIDTH] = mn_v[COUNT_WIDTH-1:0];
          end else begin
            count_d[i*COUNT_WIDTH +: COUNT_WIDTH] = wr_v[COUNT_WIDTH-1:0];
          end
          wrap_up_d[i] = 1'b1;
          carry_v      = 1'b1;
        end
      end else if (dn_v) begin
        res_v = cnt_v - stp_v;
        if (res_v >= mn_v) begin
          count_d[i*COUNT_WIDTH +: COUNT_WIDTH] = res_v[COUNT_WIDTH-1:0];
        end else if (sat_mode_i[i]) begin
          count_d[i*COUNT_WIDTH +: COUNT_WIDTH] = mn_v[COUNT_WIDTH-1:0];
          sat_hit_d[i] = 1'b1;
        end else begin
          wr_v = mx_v - (mn_v - res_v - ONE);
          if (wr_v < mn_v) begin
            count_d[i*COUNT_WIDTH +: COUNT_WIDTH] = mx_v[COUNT_WIDTH-1:0];
          end else begin
            count_d[i*COUNT_WIDTH +: COUNT_WIDTH] = wr_v[COUNT_WIDTH-1:0];
          end
          wrap_dn_d[i] = 1'b1;
        end
      end else begin
        count_d[i*COUNT_WIDTH +: COUNT_WIDTH] = count_q[i*COUNT_WIDTH +: COUNT_WIDTH];
      end
    end
  end

  // Count and event-pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q   <= default_i;
      wrap_up_q <= {NUM_CH{1'b0}};
      wrap_dn_q <= {NUM_CH{1'b0}};
      sat_hit_q <= {NUM_CH{1'b0}};
    end else begin
      count_q   <= count_d;
      wrap_up_q <= wrap_up_d;
      wrap_dn_q <= wrap_dn_d;
      sat_hit_q <= sat_hit_d;
    end
  end

  // Bound flags follow the registered count combinationally.
  always_comb begin
    at_max_o = {NUM_CH{1'b0}};
    at_min_o = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      at_max_o[i] = (count_q[i*COUNT_WIDTH +: COUNT_WIDTH] == max_count_i[i*COUNT_WIDTH +: COUNT_WIDTH]);
      at_min_o[i] = (count_q[i*COUNT_WIDTH +: COUNT_WIDTH] == min_count_i[i*COUNT_WIDTH +: COUNT_WIDTH]);
    end
  end

  assign count_o   = count_q;
  assign wrap_up_o = wrap_up_q;
  assign wrap_dn_o = wrap_dn_q;
  assign sat_hit_o = sat_hit_q;

endmodule
